dmem_vga_arbiter: RTL and testbench
===================================

Name: dmem_vga_arbiter

Overview:
- Shares the single-port data RAM between the processor load/store path and the VGA character/pixel fetcher.
- Fixed CPU priority, with a starvation counter that lets VGA win after MAX_WAIT lost cycles.
- A winning starved VGA requester then holds a short read burst.
- Sits between the processor datapath memory interface, the VGA reader and the data RAM; the processor stalls on its `cpu_gnt`.

Parameters:
- AW, 10, word-address width for all address ports.
- DW, 32, data width.
- MAX_WAIT, 4, contested cycles VGA may lose before it gets priority.
- BURST_LEN, 4, consecutive VGA grants allowed once starvation priority triggers.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held with stable address/data until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DW  CPU read data.
- vga_req  in  1  VGA read request; held until granted.
- vga_addr  in  AW  VGA word address.
- vga_gnt  out  1  VGA request accepted this cycle (combinational).
- vga_rvalid  out  1  VGA read data valid.
- vga_rdata  out  DW  VGA read data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data; synchronous, valid the cycle after mem_en.

Behaviour:
- **Reset.** While reset is high, all outputs are 0, state = NORMAL, vga_wait = 0, burst_cnt = 0, and the read-owner tag is cleared.
- **Suppressed reads.** A read issued in the cycle reset asserts never produces rvalid.
- **FSM states.** NORMAL and VGA_BURST.
- **NORMAL arbitration.**
  - If only one requester is active, it is granted.
  - If both are active and vga_wait < MAX_WAIT, CPU wins and vga_wait increments.
  - If both are active and vga_wait == MAX_WAIT, VGA wins; state goes to VGA_BURST and burst_cnt = BURST_LEN-1.
- **vga_wait counter.** Saturates at MAX_WAIT and clears on any vga_gnt.
- **VGA_BURST.**
  - vga_req=1: VGA is granted even if the CPU requests, and burst_cnt decrements.
  - Return to NORMAL when burst_cnt == 0 at a grant, or when vga_req=0 (early exit). In the vga_req=0 case the CPU is granted that same cycle if it is requesting.
  - CPU lost cycles in VGA_BURST do not count toward anything.
- **Grant drive.** At most one gnt per cycle. In the grant cycle, mem_en=1 and mem_we/mem_addr/mem_wdata come from the winner. For VGA, mem_we=0 and mem_wdata=0. With no grant, mem_* = 0.
- **Read return, 1-cycle latency.**
  - A registered tag records the owner of a read grant.
  - Next cycle, that owner's rvalid=1 and its rdata = mem_rdata. The other port's rdata holds its last value.
  - A write grant never produces rvalid.
- **Back-to-back.** Grants are allowed every cycle, with no bubble; a response and a new grant coexist in the same cycle.
- **Deasserting requests.** Dropping req before gnt is legal; the request is simply withdrawn and vga_wait is unaffected on that cycle.

Optional Feature:
- **Macro.** ARB_STATS_EN.
- **Defined.** Adds outputs `cpu_gnt_cnt` and `vga_gnt_cnt` (32 bits each) and `starve_cnt` (16 bits, counts NORMAL->VGA_BURST entries). All three saturate, are cleared by reset, and increment on the same edge that registers the grant.
- **Undefined.** The ports and counters are absent; arbitration is unchanged.

Decomposition:
- **Package `arb_pkg`.**
  - `arb_state_t` enum: NORMAL, VGA_BURST.
  - `owner_t` enum: OWN_NONE, OWN_CPU, OWN_VGA.
  - Default constants for AW/DW/MAX_WAIT/BURST_LEN.
- **Sub-module `arb_starve_ctr`.** One natural sub-module: a saturating wait counter with increment/clear inputs and an at_max output, parameterized by MAX_WAIT.

Test Plan:
- **CPU read alone.** CPU read addr 0x010, RAM[0x010]=0xDEADBEEF, vga_req=0 -> cpu_gnt same cycle, mem_addr=0x010, mem_we=0; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF next cycle; vga_rvalid stays 0.
- **CPU write.** CPU write 0x12345678 to 0x020 -> mem_we=1, mem_wdata=0x12345678 in the gnt cycle; no rvalid follows; a later read returns 0x12345678.
- **Sustained contention.** cpu_req and vga_req both held high continuously -> CPU granted 4 cycles, then VGA granted 4 consecutive cycles (VGA_BURST), then CPU granted 4 cycles; pattern repeats, and starve_cnt=2 after 16 cycles when ARB_STATS_EN is defined.
- **Burst early exit.** VGA_BURST entered, vga_req dropped after 2 grants with cpu_req=1 -> state NORMAL and cpu_gnt=1 in the same cycle vga_req is low; vga_wait=0.
- **Back-to-back owners.** VGA read 0x100 in cycle n, CPU read 0x101 in cycle n+1 -> vga_rvalid in n+1 and cpu_rvalid in n+2, with correct data and no cross-delivery.
- **Reset mid-read.** Reset asserted asynchronously in the cycle after a CPU read grant -> cpu_rvalid forced 0 immediately, all mem_* = 0, and the arbiter resumes in NORMAL with vga_wait=0 after release.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the data-RAM / VGA arbiter.
package arb_pkg;

  localparam int unsigned AW_DEF        = 10;
  localparam int unsigned DW_DEF        = 32;
  localparam int unsigned MAX_WAIT_DEF  = 4;
  localparam int unsigned BURST_LEN_DEF = 4;

  typedef enum logic {
    NORMAL,
    VGA_BURST
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_VGA
  } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of contested cycles the VGA requester has lost.
module arb_starve_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [CW-1:0] cnt_q;

  assign at_max = (cnt_q == CW'(MAX_WAIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_vga_arbiter.sv
// Single-port data RAM arbiter: CPU has fixed priority, a starved VGA reader wins a short burst.
// Optional grant/starvation statistics counters are built when ARB_STATS_EN is defined.
module dmem_vga_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]   cpu_gnt_cnt,
  output logic [31:0]   vga_gnt_cnt,
  output logic [15:0]   starve_cnt
`endif
);

  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  arb_state_t    state_q;
  logic [BW-1:0] burst_cnt_q;
  owner_t        owner_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] vga_rdata_q;
  logic          wait_max;
  logic          wait_inc;
  logic          starve_entry;

  // Grants are gated by reset so nothing reaches the RAM while reset is high.
  always_comb begin
    cpu_gnt = 1'b0;
    vga_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        NORMAL: begin
          if (cpu_req && vga_req) begin
            vga_gnt = wait_max;
            cpu_gnt = !wait_max;
          end else begin
            cpu_gnt = cpu_req;
            vga_gnt = vga_req;
          end
        end
        VGA_BURST: begin
          vga_gnt = vga_req;
          cpu_gnt = !vga_req && cpu_req;
        end
        default: ;
      endcase
    end
  end

  assign wait_inc     = (state_q == NORMAL) && cpu_gnt && vga_req;
  assign starve_entry = (state_q == NORMAL) && vga_gnt && cpu_req;

  arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (wait_inc),
    .clr   (vga_gnt),
    .at_max(wait_max)
  );

  always_comb begin
    mem_en    = cpu_gnt | vga_gnt;
    mem_we    = cpu_gnt & cpu_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (vga_gnt) begin
      mem_addr = vga_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= NORMAL;
      burst_cnt_q <= '0;
      owner_q     <= OWN_NONE;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
    end else begin
      if (vga_gnt) begin
        owner_q <= OWN_VGA;
      end else if (cpu_gnt && !cpu_we) begin
        owner_q <= OWN_CPU;
      end else begin
        owner_q <= OWN_NONE;
      end
      if (owner_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
      if (owner_q == OWN_VGA) vga_rdata_q <= mem_rdata;
      case (state_q)
        NORMAL: begin
          if (starve_entry && (BURST_LEN > 1)) begin
            state_q     <= VGA_BURST;
            burst_cnt_q <= BW'(BURST_LEN - 1);
          end
        end
        VGA_BURST: begin
          // The entry grant already counted, so leave on the grant that drains the count.
          if (vga_gnt && (burst_cnt_q > BW'(1))) begin
            burst_cnt_q <= burst_cnt_q - BW'(1);
          end else begin
            state_q     <= NORMAL;
            burst_cnt_q <= '0;
          end
        end
        default: state_q <= NORMAL;
      endcase
    end
  end

  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign vga_rvalid = (owner_q == OWN_VGA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign vga_rdata  = vga_rvalid ? mem_rdata : vga_rdata_q;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_gnt_cnt <= '0;
      vga_gnt_cnt <= '0;
      starve_cnt  <= '0;
    end else begin
      if (cpu_gnt && (cpu_gnt_cnt != '1)) cpu_gnt_cnt <= cpu_gnt_cnt + 32'd1;
      if (vga_gnt && (vga_gnt_cnt != '1)) vga_gnt_cnt <= vga_gnt_cnt + 32'd1;
      if (starve_entry && (BURST_LEN > 1) && (starve_cnt != '1)) begin
        starve_cnt <= starve_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_vga_arbiter.sv
// Scoreboard bench for dmem_vga_arbiter: directed scenarios plus randomized traffic.
module tb_dmem_vga_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int BURST_LEN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, vga_req = 1'b0;
  logic [9:0]  cpu_addr = '0, vga_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid;
  logic [31:0] cpu_rdata, vga_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
`ifdef ARB_STATS_EN
  logic [31:0] cpu_gnt_cnt, vga_gnt_cnt;
  logic [15:0] starve_cnt;
`endif

  dmem_vga_arbiter #(
    .AW(10), .DW(32), .MAX_WAIT(MAX_WAIT), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .cpu_gnt_cnt(cpu_gnt_cnt), .vga_gnt_cnt(vga_gnt_cnt), .starve_cnt(starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM seen by the arbiter.
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    bit          vga;
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t q[$];

  // Reference model: lost contests, burst grants remaining, shadow memory.
  int          lost = 0;
  bit          in_burst = 0;
  int          left = 0;
  logic [31:0] ref_mem [1024];

  task automatic step(input bit rst, input bit cr, input bit cw, input logic [9:0] ca,
                      input logic [31:0] cd, input bit vr, input logic [9:0] va,
                      output bit gc, output bit gv);
    bit          ec, ev, ewe;
    logic [9:0]  ea;
    logic [31:0] ed;
    @(posedge clk);
    #1;
    reset = rst; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    vga_req = vr; vga_addr = va;
    #3;
    ec = 0; ev = 0;
    if (!rst) begin
      if (in_burst) begin
        ev = vr; ec = !vr && cr;
      end else if (cr && vr) begin
        ev = (lost >= MAX_WAIT); ec = !ev;
      end else begin
        ec = cr; ev = vr;
      end
    end
    ewe = ec && cw;
    ea  = ec ? ca : (ev ? va : 10'h0);
    ed  = ec ? cd : 32'h0;
    n_tests++;
    if (cpu_gnt !== ec || vga_gnt !== ev || mem_en !== (ec | ev) || mem_we !== ewe ||
        mem_addr !== ea || mem_wdata !== ed) begin
      n_fail++;
      $display("FAIL grant cyc=%0d got c=%b v=%b en=%b we=%b a=%h d=%h want c=%b v=%b en=%b we=%b a=%h d=%h",
               cyc, cpu_gnt, vga_gnt, mem_en, mem_we, mem_addr, mem_wdata,
               ec, ev, ec | ev, ewe, ea, ed);
    end
    gc = cpu_gnt; gv = vga_gnt;
    if (rst) begin
      lost = 0; in_burst = 0; left = 0;
      q.delete();
    end else begin
      if (ec && !cw) q.push_back('{vga: 1'b0, data: ref_mem[ca], due: cyc + 1});
      if (ec && cw) ref_mem[ca] = cd;
      if (ev) q.push_back('{vga: 1'b1, data: ref_mem[va], due: cyc + 1});
      if (ev) begin
        if (in_burst) begin
          left--;
          if (left == 0) in_burst = 0;
        end else if (cr) begin
          left = BURST_LEN - 1;
          in_burst = (left > 0);
        end
        lost = 0;
      end else begin
        in_burst = 0;
        if (ec && vr && lost < MAX_WAIT) lost++;
      end
    end
  endtask

  // Monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    rsp_t r;
    if (cpu_rvalid || vga_rvalid) begin
      n_tests++;
      if (cpu_rvalid && vga_rvalid) begin
        n_fail++;
        $display("FAIL rsp_both cyc=%0d got both rvalid want one", cyc);
      end else if (q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected cyc=%0d got cpu_rv=%b vga_rv=%b want none",
                 cyc, cpu_rvalid, vga_rvalid);
      end else begin
        r = q.pop_front();
        if (r.vga !== vga_rvalid || r.due != cyc ||
            (vga_rvalid ? vga_rdata : cpu_rdata) !== r.data) begin
          n_fail++;
          $display("FAIL rsp_data cyc=%0d got vga=%b data=%h want vga=%b data=%h due=%0d",
                   cyc, vga_rvalid, vga_rvalid ? vga_rdata : cpu_rdata, r.vga, r.data, r.due);
        end
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_missing cyc=%0d got no rvalid want vga=%b data=%h",
               cyc, q[0].vga, q[0].data);
      void'(q.pop_front());
    end
  end

  initial begin
    bit gc, gv;
    bit [15:0] pat;
    bit cp, vp, cwr;
    logic [9:0]  ca, va;
    logic [31:0] cd;

    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[10'h010] = 32'hDEADBEEF; ref_mem[10'h010] = 32'hDEADBEEF;

    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (cpu_gnt || vga_gnt || cpu_rvalid || vga_rvalid || mem_en || mem_we ||
        mem_addr != 0 || mem_wdata != 0 || cpu_rdata != 0 || vga_rdata != 0) begin
      n_fail++;
      $display("FAIL reset_outputs got en=%b gnt=%b%b rv=%b%b want all zero",
               mem_en, cpu_gnt, vga_gnt, cpu_rvalid, vga_rvalid);
    end
    step(1, 0, 0, 0, 0, 0, 0, gc, gv);
    step(1, 1, 0, 10'h5, 0, 1, 10'h6, gc, gv);

    // CPU read alone, then write and read back.
    step(0, 1, 0, 10'h010, 32'h0, 0, 0, gc, gv);
    step(0, 0, 0, 0, 0, 0, 0, gc, gv);
    step(0, 1, 1, 10'h020, 32'h12345678, 0, 0, gc, gv);
    step(0, 0, 0, 0, 0, 0, 0, gc, gv);
    step(0, 1, 0, 10'h020, 32'h0, 0, 0, gc, gv);
    step(0, 0, 0, 0, 0, 0, 0, gc, gv);

    // Sustained contention from a clean state.
    step(1, 0, 0, 0, 0, 0, 0, gc, gv);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 10'(i), 0, 1, 10'(10'h200 + i), gc, gv);
      pat[i] = gv;
    end
    n_tests++;
    if (pat != 16'hF0F0) begin
      n_fail++;
      $display("FAIL contention_pattern got %h want f0f0", pat);
    end
`ifdef ARB_STATS_EN
    #1;
    n_tests++;
    if (starve_cnt != 16'd2) begin
      n_fail++;
      $display("FAIL starve_cnt got %0d want 2", starve_cnt);
    end
`endif

    // Burst early exit after two VGA grants.
    step(1, 0, 0, 0, 0, 0, 0, gc, gv);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 10'h30, 0, 1, 10'h40, gc, gv);
    step(0, 1, 0, 10'h31, 0, 0, 10'h40, gc, gv);
    n_tests++;
    if (!gc || gv) begin
      n_fail++;
      $display("FAIL early_exit got cpu_gnt=%b vga_gnt=%b want 1 0", gc, gv);
    end
    step(0, 1, 0, 10'h32, 0, 1, 10'h41, gc, gv);
    n_tests++;
    if (!gc || gv) begin
      n_fail++;
      $display("FAIL post_exit_wait got cpu_gnt=%b vga_gnt=%b want 1 0", gc, gv);
    end

    // Back-to-back owners.
    step(0, 0, 0, 0, 0, 1, 10'h100, gc, gv);
    step(0, 1, 0, 10'h101, 0, 0, 0, gc, gv);
    step(0, 0, 0, 0, 0, 0, 0, gc, gv);
    step(0, 0, 0, 0, 0, 0, 0, gc, gv);

    // Reset asserted in the cycle after a CPU read grant.
    step(0, 1, 0, 10'h010, 0, 0, 0, gc, gv);
    @(posedge clk);
    #2 reset = 1'b1;
    q.delete();
    lost = 0; in_burst = 0; left = 0;
    #1;
    n_tests++;
    if (cpu_rvalid || mem_en || mem_we || mem_addr != 0 || mem_wdata != 0 || cpu_gnt) begin
      n_fail++;
      $display("FAIL reset_mid_read got rv=%b en=%b we=%b a=%h gnt=%b want zeros",
               cpu_rvalid, mem_en, mem_we, mem_addr, cpu_gnt);
    end
    step(1, 1, 0, 10'h010, 0, 0, 0, gc, gv);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 10'h11, 0, 1, 10'h12, gc, gv);

    // Randomized traffic with occasional withdrawals.
    cp = 0; vp = 0; cwr = 0; ca = 0; va = 0; cd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!cp && $urandom_range(0, 2) == 0) begin
        cp = 1; cwr = $urandom_range(0, 1) == 1; ca = 10'($urandom_range(0, 63)); cd = $urandom;
      end else if (cp && $urandom_range(0, 15) == 0) begin
        cp = 0;
      end
      if (!vp && $urandom_range(0, 2) == 0) begin
        vp = 1; va = 10'($urandom_range(0, 63));
      end else if (vp && $urandom_range(0, 15) == 0) begin
        vp = 0;
      end
      step(($urandom_range(0, 99) == 0), cp, cwr, ca, cd, vp, va, gc, gv);
      if (gc) cp = 0;
      if (gv) vp = 0;
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, gc, gv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
